// File: rtl/btn_pkg.sv
// Shared definitions for the pushbutton conditioner: channel states, button indices
// and a counter-width helper.
package btn_pkg;

  localparam int unsigned NUM_BTN = 5;

  localparam int unsigned BTN_U = 0;
  localparam int unsigned BTN_D = 1;
  localparam int unsigned BTN_L = 2;
  localparam int unsigned BTN_R = 3;
  localparam int unsigned BTN_C = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    PRESSED   = 2'd2,
    RELEASING = 2'd3
  } btn_state_t;

  // Width able to hold n-1; never narrower than one bit.
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One debounced pushbutton: 2-flop synchronizer, IDLE/ARMING/PRESSED/RELEASING FSM.
// Define BTN_HOLD_REPEAT_EN to add hold-to-repeat press pulses.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 20000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic press_nxt
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]  sync_q;
  logic        sync;
  btn_state_t  state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic        level_nxt;
  logic        accept;

  assign sync = sync_q[1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        level_nxt = 1'b0;
        if (sync) begin
          state_nxt = ARMING;
          cnt_nxt   = CW'(1);
        end
      end
      ARMING: begin
        if (!sync) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          accept    = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!sync) begin
          state_nxt = RELEASING;
          cnt_nxt   = CW'(1);
        end
      end
      RELEASING: begin
        if (sync) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

`ifdef BTN_HOLD_REPEAT_EN
  localparam int unsigned RW =
    cnt_bits((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);

  logic [RW-1:0] rpt, rpt_nxt;
  logic          holding, holding_nxt;
  logic          rpt_fire;

  // One counter serves both the initial hold delay and the repeat period; it is
  // frozen in RELEASING so a bounce cannot restart the hold delay.
  always_comb begin
    rpt_nxt     = rpt;
    holding_nxt = holding;
    rpt_fire    = 1'b0;
    if (state == PRESSED && state_nxt == PRESSED) begin
      if (!holding) begin
        if (rpt == RW'(HOLD_CYCLES - 1)) begin
          rpt_fire    = 1'b1;
          holding_nxt = 1'b1;
          rpt_nxt     = '0;
        end else begin
          rpt_nxt = rpt + RW'(1);
        end
      end else if (rpt == RW'(REPEAT_CYCLES - 1)) begin
        rpt_fire = 1'b1;
        rpt_nxt  = '0;
      end else begin
        rpt_nxt = rpt + RW'(1);
      end
    end else if (state_nxt == IDLE) begin
      rpt_nxt     = '0;
      holding_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt     <= '0;
      holding <= 1'b0;
    end else begin
      rpt     <= rpt_nxt;
      holding <= holding_nxt;
    end
  end

  assign press_nxt = accept | rpt_fire;
`else
  // Hold/repeat timing has no effect in this build.
  if (HOLD_CYCLES > 0 || REPEAT_CYCLES > 0) begin : g_no_repeat
  end

  assign press_nxt = accept;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      state  <= IDLE;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      level  <= level_nxt;
      press  <= press_nxt;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Five independent debounced pushbutton channels (U, D, L, R, C) with a combined press flag.
// Define BTN_HOLD_REPEAT_EN to enable hold-to-repeat in every channel.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 20000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btnU,
  input  logic               btnD,
  input  logic               btnL,
  input  logic               btnR,
  input  logic               btnC,
  output logic [NUM_BTN-1:0] level,
  output logic [NUM_BTN-1:0] press,
  output logic               any_press
);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] press_nxt;

  assign raw = {btnC, btnR, btnL, btnD, btnU};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .raw      (raw[i]),
      .level    (level[i]),
      .press    (press[i]),
      .press_nxt(press_nxt[i])
    );
  end

  // Registered from the channels' next-press terms so it lines up with press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) any_press <= 1'b0;
    else     any_press <= |press_nxt;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with short debounce/hold/repeat timing.
module tb_btn_conditioner;
  import btn_pkg::*;

  localparam int unsigned DB  = 4;
  localparam int unsigned HC  = 20;
  localparam int unsigned RC  = 8;
  localparam int unsigned LAT = DB + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] raw = '0;
  logic [4:0] level, press;
  logic       any_press;

  int unsigned cyc    = 0;
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  typedef struct {
    int unsigned at;
    logic [4:0]  mask;
  } exp_t;
  exp_t sb[$];

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HC),
    .REPEAT_CYCLES  (RC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btnU     (raw[BTN_U]),
    .btnD     (raw[BTN_D]),
    .btnL     (raw[BTN_L]),
    .btnR     (raw[BTN_R]),
    .btnC     (raw[BTN_C]),
    .level    (level),
    .press    (press),
    .any_press(any_press)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_press(input int unsigned at, input logic [4:0] m);
    exp_t e;
    e.at   = at;
    e.mask = m;
    sb.push_back(e);
  endtask

  // Output monitor: every press pulse must match the scoreboard head exactly.
  always @(negedge clk) begin
    logic [4:0] exp_m;
    if (rst) begin
      check("rst_press", 32'(press), 0);
      check("rst_any", 32'(any_press), 0);
      check("rst_level", 32'(level), 0);
    end else begin
      exp_m = (sb.size() > 0 && sb[0].at == cyc) ? sb[0].mask : 5'b0;
      if (press != 5'b0 || exp_m != 5'b0) begin
        check("press", 32'(press), 32'(exp_m));
        check("any_press", 32'(any_press), 32'(exp_m != 5'b0));
        if (exp_m != 5'b0) void'(sb.pop_front());
      end else if (any_press) begin
        check("any_press_idle", 32'(any_press), 0);
      end
    end
  end

  initial begin
    int unsigned t;
    step(3);
    rst = 1'b0;
    step(2);

    // Clean press on U
    t = cyc;
    raw[BTN_U] = 1'b1;
    expect_press(t + LAT, 5'b00001);
    step(LAT - 1);
    check("u_level_before", 32'(level[BTN_U]), 0);
    step(1);
    check("u_level_accept", 32'(level[BTN_U]), 1);
    step(10);

    // Short release glitch on U is ignored
    raw[BTN_U] = 1'b0;
    step(2);
    raw[BTN_U] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("u_short_drop_level", 32'(level[BTN_U]), 1);
    end

    // Real release on U
    raw[BTN_U] = 1'b0;
    step(LAT - 1);
    check("u_release_hold", 32'(level[BTN_U]), 1);
    step(1);
    check("u_release_clr", 32'(level[BTN_U]), 0);
    step(4);

    // Bouncy press on L
    for (int i = 0; i < 2; i++) begin
      raw[BTN_L] = 1'b1;
      step(2);
      raw[BTN_L] = 1'b0;
      step(2);
    end
    t = cyc;
    raw[BTN_L] = 1'b1;
    expect_press(t + LAT, 5'b00100);
    step(LAT - 1);
    check("l_level_bounce", 32'(level[BTN_L]), 0);
    step(1);
    check("l_level", 32'(level[BTN_L]), 1);
    raw[BTN_L] = 1'b0;
    step(LAT + 2);
    check("l_level_release", 32'(level[BTN_L]), 0);

    // Simultaneous R and C
    t = cyc;
    raw[BTN_R] = 1'b1;
    raw[BTN_C] = 1'b1;
    expect_press(t + LAT, 5'b11000);
    step(LAT);
    check("rc_level", 32'(level), 32'(5'b11000));
    raw[BTN_R] = 1'b0;
    raw[BTN_C] = 1'b0;
    step(LAT + 2);
    check("rc_level_release", 32'(level), 0);

    // Reset pulse while D is arming (counter=2)
    raw[BTN_D] = 1'b1;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    t = cyc;
    expect_press(t + LAT, 5'b00010);
    step(LAT - 1);
    check("d_level_before", 32'(level[BTN_D]), 0);
    step(1);
    check("d_level", 32'(level[BTN_D]), 1);
    raw[BTN_D] = 1'b0;
    step(LAT + 2);

    // Long hold on C
    t = cyc;
    raw[BTN_C] = 1'b1;
    expect_press(t + LAT, 5'b10000);
`ifdef BTN_HOLD_REPEAT_EN
    expect_press(t + LAT + HC, 5'b10000);
    expect_press(t + LAT + HC + RC, 5'b10000);
    expect_press(t + LAT + HC + 2 * RC, 5'b10000);
`endif
    step(LAT + 39);
    check("c_level_held", 32'(level[BTN_C]), 1);
    raw[BTN_C] = 1'b0;
    step(LAT + 4);
    check("c_level_release", 32'(level[BTN_C]), 0);

    step(10);
    check("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
